// File: rtl/tristate_tx_driver.sv
// Half-duplex single-wire transmitter: START(1), DATA_W bits LSB first, STOP(0), then TURN_CYC released cycles.
// Define TRISTATE_TX_NATIVE_Z_EN to add the resolved inout port `pad`.
module tristate_tx_driver #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TURN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              pad_o,
    output logic              pad_oe,
    output logic              busy,
    output logic              done
`ifdef TRISTATE_TX_NATIVE_Z_EN
    ,
    inout  wire               pad
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       TURN_LOAD = 4'(TURN_CYC - 1);

    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("tristate_tx_driver: DATA_W must be within 2..32");
    end
    if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn_cyc
        $error("tristate_tx_driver: TURN_CYC must be within 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        TURN
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]  r_bit,   w_bit_nxt;
    logic [3:0]        r_turn,  w_turn_nxt;
    logic              r_pad_o, r_pad_oe, r_busy, r_done, r_ready;
    logic              w_pad_o_nxt, w_pad_oe_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_turn_nxt  = r_turn;
        unique case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_shift_nxt = tx_data;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = DATA;
            DATA: begin
                w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                if (r_bit == LAST_BIT) begin
                    w_state_nxt = STOP;
                end else begin
                    w_bit_nxt = r_bit + 1'b1;
                end
            end
            STOP: begin
                w_turn_nxt  = TURN_LOAD;
                w_state_nxt = TURN;
            end
            TURN: begin
                if (r_turn == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_turn_nxt = r_turn - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so in DATA the post-shift LSB is what goes on the pad.
    always_comb begin
        w_pad_oe_nxt = (w_state_nxt == START) || (w_state_nxt == DATA) || (w_state_nxt == STOP);
        w_pad_o_nxt  = 1'b0;
        if (w_state_nxt == START) begin
            w_pad_o_nxt = 1'b1;
        end else if (w_state_nxt == DATA) begin
            w_pad_o_nxt = w_shift_nxt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_turn   <= '0;
            r_pad_o  <= 1'b0;
            r_pad_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
            r_turn   <= w_turn_nxt;
            r_pad_o  <= w_pad_o_nxt;
            r_pad_oe <= w_pad_oe_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (r_state == STOP);
            r_ready  <= (w_state_nxt == IDLE);
        end
    end

    assign pad_o    = r_pad_o;
    assign pad_oe   = r_pad_oe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_ready = r_ready;

`ifdef TRISTATE_TX_NATIVE_Z_EN
    assign pad = r_pad_oe ? r_pad_o : 1'bz;
`endif

`ifdef FORMAL
    always_comb begin
        if (!r_pad_oe) begin
            assert (!r_pad_o && (r_state == IDLE || r_state == TURN));
        end
    end
`endif

endmodule
